// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM array: frame FSM states,
// alignment mode encodings and the centre-aligned offset calculation.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_LEFT   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Start slot of a centred pulse of width duty inside a period of period slots.
    function automatic int unsigned centre_off(input int unsigned period,
                                               input int unsigned duty);
        return (period - duty) >> 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: holds its duty register, compares it against the shared
// frame counter and drives a registered pulse output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned WORD_W = 10,
    parameter int unsigned RES_W  = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              capture_i,
    input  logic              run_i,
    input  logic              mode_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [RES_W-1:0]  cnt_i,
    output logic              pwm_o
);

    localparam int unsigned P = 1 << RES_W;

    logic [RES_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic [RES_W:0]   off, cnt_x, duty_x;
    logic             hit;
    logic             word_unused;

    // Low-order word bits are below the duty resolution and are discarded.
    assign word_unused = ^word_i;

    // Duty capture and hit test; offset math is one bit wider so duty=0 cannot overflow.
    always_comb begin
        duty_d = duty_q;
        if (capture_i) begin
            duty_d = word_i[WORD_W-1 -: RES_W];
        end
        cnt_x  = {1'b0, cnt_i};
        duty_x = {1'b0, duty_q};
        off    = (RES_W+1)'(centre_off(P, 32'(duty_q)));
        if (mode_i == MODE_CENTER) begin
            hit = (cnt_x >= off) && (cnt_x < off + duty_x);
        end else begin
            hit = (cnt_i < duty_q);
        end
        pwm_d = run_i ? hit : 1'b0;
    end

    // Duty and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM generator: a shared frame counter and start/done FSM
// drive NCH aligned pulse channels, single-shot or continuous.
module pwm_array
    import pwm_pkg::*;
#(
    parameter int unsigned NCH    = 8,
    parameter int unsigned WORD_W = 10,
    parameter int unsigned RES_W  = 7
) (
    input  logic                  clk_1Mhz,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  mode,
    input  logic [NCH*WORD_W-1:0] words,
    output logic [NCH-1:0]        pwm,
    output logic                  busy,
    output logic                  done
);

    state_e           state_q, state_d;
    logic [RES_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic             capture;
    logic             run_en;

    // Next-state logic: frame start, per-slot counting, boundary reload or exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        capture = 1'b0;
        run_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    mode_d  = mode;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_en = 1'b1;
                cnt_d  = cnt_q + RES_W'(1);
                if (cnt_q == '1) begin
                    if (cont) begin
                        capture = 1'b1;
                        mode_d  = mode;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and handshake registers.
    always_ff @(posedge clk_1Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= MODE_LEFT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel #(
            .WORD_W (WORD_W),
            .RES_W  (RES_W)
        ) u_ch (
            .clk_i     (clk_1Mhz),
            .rst_ni    (reset_n),
            .capture_i (capture),
            .run_i     (run_en),
            .mode_i    (mode_q),
            .word_i    (words[i*WORD_W +: WORD_W]),
            .cnt_i     (cnt_q),
            .pwm_o     (pwm[i])
        );
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_array.sv
// Directed bench for pwm_array: left/centre pulse widths, boundary words,
// handshake, continuous reload, cont drop and mid-frame reset.
module tb_pwm_array;

    localparam int NCH    = 8;
    localparam int WORD_W = 10;
    localparam int RES_W  = 7;

    logic                  clk_1Mhz = 1'b0;
    logic                  reset_n;
    logic                  start;
    logic                  cont;
    logic                  mode;
    logic [NCH*WORD_W-1:0] words;
    logic [NCH-1:0]        pwm;
    logic                  busy;
    logic                  done;

    int n_checks = 0;
    int n_errors = 0;

    logic [NCH-1:0] pwm_log  [0:299];
    logic           done_log [0:299];
    logic           busy_log [0:299];

    pwm_array #(
        .NCH    (NCH),
        .WORD_W (WORD_W),
        .RES_W  (RES_W)
    ) dut (
        .clk_1Mhz (clk_1Mhz),
        .reset_n  (reset_n),
        .start    (start),
        .cont     (cont),
        .mode     (mode),
        .words    (words),
        .pwm      (pwm),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_1Mhz = ~clk_1Mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1Mhz);
        #1;
    endtask

    task automatic sample(input int k);
        pwm_log[k]  = pwm;
        done_log[k] = done;
        busy_log[k] = busy;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 300; k++) begin
            pwm_log[k]  = '0;
            done_log[k] = 1'b0;
            busy_log[k] = 1'b0;
        end
    endtask

    task automatic set_word(input int ch, input int w);
        words[ch*WORD_W +: WORD_W] = WORD_W'(w);
    endtask

    // Edge e0: start is seen in IDLE.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int count_high(input int ch, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (pwm_log[k][ch]) n++;
        return n;
    endfunction

    function automatic int first_high(input int ch, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (pwm_log[k][ch]) return k;
        return -1;
    endfunction

    function automatic int last_high(input int ch, input int lo, input int hi);
        int r = -1;
        for (int k = lo; k <= hi; k++) if (pwm_log[k][ch]) r = k;
        return r;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (done_log[k]) n++;
        return n;
    endfunction

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        cont    = 1'b0;
        mode    = 1'b0;
        words   = '0;
        #12;
        check("rst_pwm",  32'(pwm),  0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        tick();
        tick();

        // Left-aligned single shot with boundary words.
        clear_logs();
        set_word(0, 80);
        set_word(1, 0);
        set_word(2, 1023);
        set_word(3, 7);
        set_word(4, 512);
        mode = 1'b0;
        cont = 1'b0;
        kick();
        check("A_busy_e0", 32'(busy), 1);
        for (int k = 1; k <= 131; k++) begin
            tick();
            sample(k);
        end
        check("A_ch0_cnt",   32'(count_high(0, 1, 131)), 10);
        check("A_ch0_first", 32'(first_high(0, 1, 131)), 1);
        check("A_ch0_last",  32'(last_high(0, 1, 131)),  10);
        check("A_ch1_cnt",   32'(count_high(1, 1, 131)), 0);
        check("A_ch2_cnt",   32'(count_high(2, 1, 131)), 127);
        check("A_ch2_last",  32'(last_high(2, 1, 131)),  127);
        check("A_ch3_cnt",   32'(count_high(3, 1, 131)), 0);
        check("A_ch4_cnt",   32'(count_high(4, 1, 131)), 64);
        check("A_done_e129", 32'(done_log[129]), 1);
        check("A_done_cnt",  32'(count_done(1, 131)), 1);
        check("A_busy_e128", 32'(busy_log[128]), 1);
        check("A_busy_e129", 32'(busy_log[129]), 0);
        check("A_pwm_e129",  32'(pwm_log[129]), 0);

        // Centre-aligned single shot.
        clear_logs();
        words = '0;
        set_word(0, 80);
        set_word(1, 1023);
        set_word(2, 8);
        set_word(3, 0);
        mode = 1'b1;
        kick();
        mode = 1'b0;
        for (int k = 1; k <= 131; k++) begin
            tick();
            sample(k);
        end
        check("B_ch0_cnt",   32'(count_high(0, 1, 131)), 10);
        check("B_ch0_first", 32'(first_high(0, 1, 131)), 60);
        check("B_ch0_last",  32'(last_high(0, 1, 131)),  69);
        check("B_ch1_cnt",   32'(count_high(1, 1, 131)), 127);
        check("B_ch1_first", 32'(first_high(1, 1, 131)), 1);
        check("B_ch2_cnt",   32'(count_high(2, 1, 131)), 1);
        check("B_ch2_first", 32'(first_high(2, 1, 131)), 64);
        check("B_ch3_cnt",   32'(count_high(3, 1, 131)), 0);
        check("B_done_e129", 32'(done_log[129]), 1);

        // Continuous: ignored restart, mid-frame word change, cont drop at e200.
        clear_logs();
        words = '0;
        set_word(0, 80);
        mode = 1'b0;
        cont = 1'b1;
        kick();
        for (int k = 1; k <= 260; k++) begin
            tick();
            sample(k);
            if (k == 4)   start = 1'b1;
            if (k == 5)   start = 1'b0;
            if (k == 49)  set_word(0, 160);
            if (k == 199) cont = 1'b0;
        end
        check("C_f1_cnt",    32'(count_high(0, 1, 128)),   10);
        check("C_f1_first",  32'(first_high(0, 1, 128)),   1);
        check("C_f2_cnt",    32'(count_high(0, 129, 260)), 20);
        check("C_f2_first",  32'(first_high(0, 129, 260)), 129);
        check("C_f2_last",   32'(last_high(0, 129, 260)),  148);
        check("C_done_e128", 32'(done_log[128]), 1);
        check("C_done_e257", 32'(done_log[257]), 1);
        check("C_done_cnt",  32'(count_done(1, 260)), 2);
        check("C_busy_e200", 32'(busy_log[200]), 1);
        check("C_busy_e256", 32'(busy_log[256]), 1);
        check("C_busy_e257", 32'(busy_log[257]), 0);
        check("C_pwm_e257",  32'(pwm_log[257]), 0);

        // Reset in the middle of a centred pulse, then a clean frame.
        clear_logs();
        words = '0;
        set_word(0, 80);
        mode = 1'b1;
        kick();
        mode = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            sample(k);
        end
        check("D_pwm_pre", 32'(pwm_log[60][0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("D_rst_pwm",  32'(pwm),  0);
        check("D_rst_busy", 32'(busy), 0);
        check("D_rst_done", 32'(done), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("D_idle_busy", 32'(busy), 0);
        check("D_idle_pwm",  32'(pwm),  0);
        clear_logs();
        kick();
        for (int k = 1; k <= 131; k++) begin
            tick();
            sample(k);
        end
        check("D_ch0_cnt",   32'(count_high(0, 1, 131)), 10);
        check("D_ch0_first", 32'(first_high(0, 1, 131)), 1);
        check("D_done_e129", 32'(done_log[129]), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
